// File: rtl/memory_responder.sv
// Memory-side responder for the control unit's Read/Write strobe interface:
// single-port word RAM with programmable access latency and Ready/Err pulses.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_op_wr;
  logic                  w_accept;
  logic                  w_rd_done;
  logic                  w_mem_we;
  logic                  w_ready_next;
  logic                  w_err_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // RELEASE holds off re-acceptance until both strobes drop, so a held strobe
  // produces exactly one access.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_rd_done    = 1'b0;
    w_mem_we     = 1'b0;
    w_ready_next = 1'b0;
    w_err_next   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Read && Write) begin
          w_err_next   = 1'b1;
          w_state_next = S_RELEASE;
        end else if (Read || Write) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
          w_rd_done    = ~r_op_wr;
          w_mem_we     = r_op_wr;
          w_ready_next = 1'b1;
          w_state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!Read && !Write) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch, read-data register and response pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_op_wr <= 1'b0;
      DataOut <= '0;
      Ready   <= 1'b0;
      Err     <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      Ready <= w_ready_next;
      Err   <= w_err_next;
      if (w_accept) begin
        r_addr  <= Address;
        r_data  <= DataIn;
        r_op_wr <= Write;
      end
      if (w_rd_done) begin
        DataOut <= r_mem[r_addr];
      end
    end
  end

  // RAM array is deliberately not reset; an aborted write never reaches here
  // because reset forces the state out of BUSY.
  always_ff @(posedge Clock) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_data;
    end
  end

  assign Busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: four latency builds share one stimulus stream,
// each checked every cycle against a transaction-level reference model.
module tb_memory_responder;

  localparam int unsigned NI = 4;

  function automatic int unsigned lat_of(input int idx);
    case (idx)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 15;
    endcase
  endfunction

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [8:0]  Address = '0;
  logic [31:0] DataIn = '0;

  logic [31:0] dout [NI];
  logic        rdy  [NI];
  logic        bsy  [NI];
  logic        err  [NI];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int rdy_cnt [NI];
  int rdy_cyc [NI];
  int err_cnt [NI];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = lat_of(g);

    memory_responder #(
      .ADDR_WIDTH(9),
      .DATA_WIDTH(32),
      .LATENCY   (L)
    ) u_dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Read   (Read),
      .Write  (Write),
      .Address(Address),
      .DataIn (DataIn),
      .DataOut(dout[g]),
      .Ready  (rdy[g]),
      .Busy   (bsy[g]),
      .Err    (err[g])
    );

    // Transaction-level model: an accepted request completes L edges later;
    // afterwards the responder waits for both strobes low before the next one.
    logic [31:0] mem [int];
    bit          in_flight = 0;
    bit          in_rel = 0;
    int          n = 0;
    int          due = 0;
    bit          op_wr = 0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] e_dout = '0;
    bit          e_dk = 1;
    bit          e_rdy = 0;
    bit          e_err = 0;

    always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        in_flight = 0;
        in_rel    = 0;
        e_dout    = '0;
        e_dk      = 1;
        e_rdy     = 0;
        e_err     = 0;
      end else begin
        n++;
        e_rdy = 0;
        e_err = 0;
        if (in_flight) begin
          if (n == due) begin
            if (op_wr) begin
              mem[int'(m_addr)] = m_data;
            end else if (mem.exists(int'(m_addr))) begin
              e_dout = mem[int'(m_addr)];
              e_dk   = 1;
            end else begin
              e_dk = 0;
            end
            e_rdy     = 1;
            in_flight = 0;
            in_rel    = 1;
          end
        end else if (in_rel) begin
          if (!Read && !Write) in_rel = 0;
        end else if (Read && Write) begin
          e_err  = 1;
          in_rel = 1;
        end else if (Read || Write) begin
          in_flight = 1;
          due       = n + int'(L);
          op_wr     = Write;
          m_addr    = Address;
          m_data    = DataIn;
        end
      end
    end

    always @(negedge Clock) begin
      if (mon_en) begin
        chk($sformatf("busy_L%0d", L),  32'(bsy[g]), 32'(in_flight | in_rel));
        chk($sformatf("ready_L%0d", L), 32'(rdy[g]), 32'(e_rdy));
        chk($sformatf("err_L%0d", L),   32'(err[g]), 32'(e_err));
        if (e_dk) chk($sformatf("dout_L%0d", L), dout[g], e_dout);
      end
      if (rdy[g] === 1'b1) begin
        rdy_cnt[g] = rdy_cnt[g] + 1;
        rdy_cyc[g] = cyc;
      end
      if (err[g] === 1'b1) err_cnt[g] = err_cnt[g] + 1;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #3;
  endtask

  task automatic wait_all_idle();
    int k = 0;
    while ((bsy[0] | bsy[1] | bsy[2] | bsy[3]) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still high after %0d cycles", k);
    end
  endtask

  // One strobe assertion; a/d switch to a2/d2 after the accept edge.
  task automatic do_op(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] d,
                       input logic [8:0] a2, input logic [31:0] d2, input int hold);
    int acc;
    int base_r [NI];
    int base_e [NI];
    for (int i = 0; i < NI; i++) begin
      base_r[i] = rdy_cnt[i];
      base_e[i] = err_cnt[i];
    end
    Read = rd; Write = wr; Address = a; DataIn = d;
    acc = cyc + 1;
    tick();
    Address = a2; DataIn = d2;
    repeat (hold - 1) tick();
    chk("held_in_release_L1", 32'(bsy[0]), 32'd1);
    Read = 1'b0; Write = 1'b0;
    tick();
    chk("idle_after_release_L1", 32'(bsy[0]), 32'd0);
    wait_all_idle();
    tick();
    for (int i = 0; i < NI; i++) begin
      if (rd ^ wr) begin
        chk($sformatf("ready_count_L%0d", lat_of(i)), 32'(rdy_cnt[i] - base_r[i]), 32'd1);
        chk($sformatf("ready_latency_L%0d", lat_of(i)), 32'(rdy_cyc[i] - acc), 32'(lat_of(i)));
        chk($sformatf("no_err_L%0d", lat_of(i)), 32'(err_cnt[i] - base_e[i]), 32'd0);
      end else begin
        chk($sformatf("conflict_no_ready_L%0d", lat_of(i)), 32'(rdy_cnt[i] - base_r[i]), 32'd0);
        chk($sformatf("conflict_err_L%0d", lat_of(i)), 32'(err_cnt[i] - base_e[i]), 32'd1);
      end
    end
  endtask

  task automatic wr_op(input logic [8:0] a, input logic [31:0] d);
    do_op(1'b0, 1'b1, a, d, a, d, 2);
  endtask

  task automatic rd_expect(input logic [8:0] a, input logic [31:0] exp, input string nm);
    do_op(1'b1, 1'b0, a, '0, a, '0, 2);
    for (int i = 0; i < NI; i++) chk($sformatf("%s_L%0d", nm, lat_of(i)), dout[i], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rdy_cnt[i] = 0; rdy_cyc[i] = 0; err_cnt[i] = 0;
    end
    #1 Reset = 1'b1;
    mon_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_dout",  dout[i], 32'h0);
      chk("reset_ready", 32'(rdy[i]), 32'd0);
      chk("reset_busy",  32'(bsy[i]), 32'd0);
      chk("reset_err",   32'(err[i]), 32'd0);
    end
    Reset = 1'b0;
    tick();

    // Known background contents.
    for (int a = 0; a < 16; a++) wr_op(9'(a), 32'hA5000000 | 32'(a));
    wr_op(9'h001, 32'h00000011);
    wr_op(9'h011, 32'h11111111);
    wr_op(9'h020, 32'h20202020);
    wr_op(9'h030, 32'h30303030);

    // Write then read back, strobes held 4 cycles.
    do_op(1'b0, 1'b1, 9'h05A, 32'hDEADBEEF, 9'h05A, 32'hDEADBEEF, 4);
    do_op(1'b1, 1'b0, 9'h05A, 32'h0, 9'h05A, 32'h0, 4);
    tick();
    for (int i = 0; i < NI; i++) chk("readback_05A_hold", dout[i], 32'hDEADBEEF);

    // Read strobe held 10 cycles: one access only.
    do_op(1'b1, 1'b0, 9'h001, 32'h0, 9'h001, 32'h0, 10);
    for (int i = 0; i < NI; i++) chk("held_read_001", dout[i], 32'h00000011);

    // Address/data changes after acceptance are ignored.
    do_op(1'b0, 1'b1, 9'h010, 32'h12345678, 9'h011, 32'hFFFFFFFF, 3);
    rd_expect(9'h010, 32'h12345678, "busy_change_010");
    rd_expect(9'h011, 32'h11111111, "busy_change_011");

    // Read and Write together.
    do_op(1'b1, 1'b1, 9'h020, 32'h99999999, 9'h020, 32'h99999999, 3);
    rd_expect(9'h020, 32'h20202020, "conflict_020");

    // Reset two cycles after acceptance aborts the slower builds' write.
    Write = 1'b1; Address = 9'h030; DataIn = 32'hCAFEF00D;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("midrst_busy",  32'(bsy[i]), 32'd0);
      chk("midrst_ready", 32'(rdy[i]), 32'd0);
      chk("midrst_dout",  dout[i], 32'h0);
    end
    Write = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    do_op(1'b1, 1'b0, 9'h030, 32'h0, 9'h030, 32'h0, 2);
    for (int i = 0; i < NI; i++)
      chk($sformatf("midrst_readback_L%0d", lat_of(i)), dout[i],
          (lat_of(i) <= 2) ? 32'hCAFEF00D : 32'h30303030);

    // Random strobes, addresses, data and occasional resets.
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 9) >= 6) begin
        Read  = ($urandom_range(0, 2) == 0);
        Write = ($urandom_range(0, 2) == 0);
      end
      Address = 9'($urandom_range(0, 15));
      DataIn  = $urandom;
      Reset   = ($urandom_range(0, 119) == 0);
      tick();
    end
    Reset = 1'b0; Read = 1'b0; Write = 1'b0;
    tick();
    wait_all_idle();
    tick();
    rd_expect(9'h05A, 32'hDEADBEEF, "final_05A");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
